// File: rtl/lbus_source_sequencer_pkg.sv
// Shared types for the L-bus source sequencer.
//   NUM_SPECIAL      : number of non-GPR selector codes that follow the GPRs
//   lbus_special_e   : special-source index (sel - NUM_GPR)
//   lbus_sel4_e      : legacy fixed 4-bit selector encoding (NUM_GPR = 8)
//   LBUS_SEQ_STATE   : sequencer FSM state
//   lbus_sel_width() : selector width for a given GPR count
package package_lbus_source_selector;

  localparam int NUM_SPECIAL = 8;

  typedef enum logic [2:0] {
    SPC_RB  = 3'd0,
    SPC_RBP = 3'd1,
    SPC_PC  = 3'd2,
    SPC_IO  = 3'd3,
    SPC_MM  = 3'd4,
    SPC_IR  = 3'd5,
    SPC_FSR = 3'd6,
    SPC_NLB = 3'd7
  } lbus_special_e;

  typedef enum logic [3:0] {
    LSEL_R0  = 4'd0,
    LSEL_R1  = 4'd1,
    LSEL_R2  = 4'd2,
    LSEL_R3  = 4'd3,
    LSEL_R4  = 4'd4,
    LSEL_R5  = 4'd5,
    LSEL_R6  = 4'd6,
    LSEL_R7  = 4'd7,
    LSEL_RB  = 4'd8,
    LSEL_RBP = 4'd9,
    LSEL_PC  = 4'd10,
    LSEL_IO  = 4'd11,
    LSEL_MM  = 4'd12,
    LSEL_IR  = 4'd13,
    LSEL_FSR = 4'd14,
    LSEL_NLB = 4'd15
  } lbus_sel4_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_IO = 2'd1,
    ST_WAIT_MM = 2'd2
  } LBUS_SEQ_STATE;

  function automatic int lbus_sel_width(input int num_gpr);
    return $clog2(num_gpr + NUM_SPECIAL);
  endfunction

endpackage

// File: rtl/lbus_source_sequencer_slow_handshake.sv
// lbus_slow_handshake: registered req/ack handshake with a timeout counter
// for one slow L-bus source.
//   clk, n_rst : clock, asynchronous active-low reset
//   start      : one-cycle launch from the parent (only when no slow source busy)
//   ack        : source data valid
//   req        : registered request, high from launch until ack or timeout
//   ack_done   : ack sampled while requesting (this edge completes with data)
//   to_done    : timeout reached without ack on this edge
module lbus_slow_handshake #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic n_rst,
  input  logic start,
  input  logic ack,
  output logic req,
  output logic ack_done,
  output logic to_done
);

  localparam int CNT_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam int LAST_I    = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_I);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [CNT_W-1:0] cnt;
  logic             to_hit;

  // Counter value c during a cycle means c edges have passed since launch,
  // so matching TIMEOUT_CYCLES-1 keeps req high for exactly TIMEOUT_CYCLES.
  assign to_hit   = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
  assign ack_done = req && ack;
  assign to_done  = req && !ack && to_hit;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      req <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      req <= 1'b1;
      cnt <= '0;
    end else if (req) begin
      if (ack || to_hit) begin
        req <= 1'b0;
      end else if (cnt != CNT_MAX) begin
        // Saturate so a disabled timeout never wraps into a false match.
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lbus_source_sequencer.sv
// lbus_source_sequencer: registered L-bus source stage.
// Handshake: a transfer starts on an edge where issue=1 and ready=1; issue
// while ready=0 is dropped. lbus_valid pulses for one cycle whenever
// lbus_data is updated. Slow sources hold req high until ack is sampled
// high or the timeout expires; acks seen while not requesting are ignored.
//   clk, n_rst        : clock, asynchronous active-low reset
//   issue, sel        : transfer request and source selector
//   ready             : idle, can accept issue
//   gpr_data          : flattened GPR file, R0 in LSBs
//   rb/rbp/pc/ir/fsr  : fast special sources
//   io_*, mm_*        : slow source handshakes
//   lbus_data/valid   : registered bus value and update pulse
//   sel_err           : illegal selector pulse (with valid)
//   timeout_err       : sticky timeout flag, cleared by err_clr
//   state_dbg         : current FSM state
module lbus_source_sequencer
  import package_lbus_source_selector::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_GPR        = 8,
  parameter int SEL_WIDTH      = lbus_sel_width(NUM_GPR),
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          issue,
  input  logic [SEL_WIDTH-1:0]          sel,
  output logic                          ready,
  input  logic [NUM_GPR*DATA_WIDTH-1:0] gpr_data,
  input  logic [DATA_WIDTH-1:0]         rb_data,
  input  logic [DATA_WIDTH-1:0]         rbp_data,
  input  logic [DATA_WIDTH-1:0]         pc_data,
  input  logic [DATA_WIDTH-1:0]         ir_data,
  input  logic [DATA_WIDTH-1:0]         fsr_data,
  output logic                          io_req,
  input  logic                          io_ack,
  input  logic [DATA_WIDTH-1:0]         io_rdata,
  output logic                          mm_req,
  input  logic                          mm_ack,
  input  logic [DATA_WIDTH-1:0]         mm_rdata,
  output logic [DATA_WIDTH-1:0]         lbus_data,
  output logic                          lbus_valid,
  output logic                          sel_err,
  output logic                          timeout_err,
  input  logic                          err_clr,
  output LBUS_SEQ_STATE                 state_dbg
);

  localparam int GPR_IDX_W = $clog2(NUM_GPR);

  LBUS_SEQ_STATE state, state_nx;

  logic [DATA_WIDTH-1:0] gpr_arr [NUM_GPR];
  logic [DATA_WIDTH-1:0] fast_value;
  logic [2:0]            spc_raw;
  logic                  is_io, is_mm, illegal;
  logic                  slow_busy, accept;
  logic                  io_start, mm_start;
  logic                  io_ack_done, io_to_done, mm_ack_done, mm_to_done;
  logic                  io_finish, mm_finish;

  for (genvar g = 0; g < NUM_GPR; g++) begin : g_gpr
    assign gpr_arr[g] = gpr_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign spc_raw = 3'(sel - SEL_WIDTH'(NUM_GPR));

  // Selector decode; NLB and illegal codes both put zero on the bus.
  always_comb begin
    fast_value = '0;
    is_io      = 1'b0;
    is_mm      = 1'b0;
    illegal    = 1'b0;
    if (int'(sel) < NUM_GPR) begin
      fast_value = gpr_arr[sel[GPR_IDX_W-1:0]];
    end else if (int'(sel) - NUM_GPR >= NUM_SPECIAL) begin
      illegal = 1'b1;
    end else begin
      case (lbus_special_e'(spc_raw))
        SPC_RB:  fast_value = rb_data;
        SPC_RBP: fast_value = rbp_data;
        SPC_PC:  fast_value = pc_data;
        SPC_IO:  is_io      = 1'b1;
        SPC_MM:  is_mm      = 1'b1;
        SPC_IR:  fast_value = ir_data;
        SPC_FSR: fast_value = fsr_data;
        default: fast_value = '0;
      endcase
    end
  end

  // Only one slow source may be in flight at a time.
  assign slow_busy = io_req || mm_req;
  assign accept    = issue && (state == ST_IDLE);
  assign io_start  = accept && is_io && !slow_busy;
  assign mm_start  = accept && is_mm && !slow_busy;
  assign io_finish = (state == ST_WAIT_IO) && (io_ack_done || io_to_done);
  assign mm_finish = (state == ST_WAIT_MM) && (mm_ack_done || mm_to_done);

  lbus_slow_handshake #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_io_hs (
    .clk      (clk),
    .n_rst    (n_rst),
    .start    (io_start),
    .ack      (io_ack),
    .req      (io_req),
    .ack_done (io_ack_done),
    .to_done  (io_to_done)
  );

  lbus_slow_handshake #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_mm_hs (
    .clk      (clk),
    .n_rst    (n_rst),
    .start    (mm_start),
    .ack      (mm_ack),
    .req      (mm_req),
    .ack_done (mm_ack_done),
    .to_done  (mm_to_done)
  );

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (io_start)      state_nx = ST_WAIT_IO;
        else if (mm_start) state_nx = ST_WAIT_MM;
      end
      ST_WAIT_IO: if (io_finish) state_nx = ST_IDLE;
      ST_WAIT_MM: if (mm_finish) state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    ready     = (state == ST_IDLE);
    state_dbg = state;
  end

  // Bus datapath and error flags.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      lbus_data   <= '0;
      lbus_valid  <= 1'b0;
      sel_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      lbus_valid <= 1'b0;
      sel_err    <= 1'b0;
      if (accept && !is_io && !is_mm) begin
        lbus_data  <= fast_value;
        lbus_valid <= 1'b1;
        sel_err    <= illegal;
      end else if (io_finish) begin
        lbus_data  <= io_ack_done ? io_rdata : '0;
        lbus_valid <= 1'b1;
      end else if (mm_finish) begin
        lbus_data  <= mm_ack_done ? mm_rdata : '0;
        lbus_valid <= 1'b1;
      end
      // A timeout on the same edge as err_clr keeps the flag set.
      if ((io_finish && io_to_done) || (mm_finish && mm_to_done)) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lbus_source_sequencer.sv
module tb_lbus_source_sequencer;
  import package_lbus_source_selector::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT with 8 GPRs ----------------
  logic        issue, io_ack, mm_ack, err_clr;
  logic [3:0]  sel;
  logic [127:0] gpr8;
  logic [15:0] rb_d, rbp_d, pc_d, ir_d, fsr_d, io_rdata, mm_rdata;
  logic        ready, io_req, mm_req, lbus_valid, sel_err, timeout_err;
  logic [15:0] lbus_data;
  LBUS_SEQ_STATE st8;

  lbus_source_sequencer #(.DATA_WIDTH(16), .NUM_GPR(8), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .n_rst(n_rst), .issue(issue), .sel(sel), .ready(ready),
    .gpr_data(gpr8), .rb_data(rb_d), .rbp_data(rbp_d), .pc_data(pc_d),
    .ir_data(ir_d), .fsr_data(fsr_d),
    .io_req(io_req), .io_ack(io_ack), .io_rdata(io_rdata),
    .mm_req(mm_req), .mm_ack(mm_ack), .mm_rdata(mm_rdata),
    .lbus_data(lbus_data), .lbus_valid(lbus_valid), .sel_err(sel_err),
    .timeout_err(timeout_err), .err_clr(err_clr), .state_dbg(st8)
  );

  // ---------------- DUT with 16 GPRs ----------------
  logic        issue16, mm_ack16;
  logic [4:0]  sel16;
  logic [255:0] gpr16;
  logic        ready16, io_req16, mm_req16, valid16, sel_err16, to_err16;
  logic [15:0] data16;
  LBUS_SEQ_STATE st16;

  lbus_source_sequencer #(.DATA_WIDTH(16), .NUM_GPR(16), .TIMEOUT_CYCLES(15)) dut16 (
    .clk(clk), .n_rst(n_rst), .issue(issue16), .sel(sel16), .ready(ready16),
    .gpr_data(gpr16), .rb_data(rb_d), .rbp_data(rbp_d), .pc_data(pc_d),
    .ir_data(ir_d), .fsr_data(fsr_d),
    .io_req(io_req16), .io_ack(1'b0), .io_rdata(16'h0000),
    .mm_req(mm_req16), .mm_ack(mm_ack16), .mm_rdata(16'h7777),
    .lbus_data(data16), .lbus_valid(valid16), .sel_err(sel_err16),
    .timeout_err(to_err16), .err_clr(1'b0), .state_dbg(st16)
  );

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // inputs change 1 time unit after the active edge; outputs are read there too
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        issue;
    logic [3:0]  sel;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic        exp_sel_err;
  } vec_t;

  vec_t vecs[$];
  logic [15:0] exp_q[$];

  initial begin
    int cyc;
    logic both_req, spurious;

    issue = 0; sel = 0; io_ack = 0; mm_ack = 0; err_clr = 0;
    io_rdata = 16'h0; mm_rdata = 16'h0;
    issue16 = 0; sel16 = 0; mm_ack16 = 0;
    for (int i = 0; i < 8; i++) gpr8[i*16 +: 16] = 16'h1000 + 16'(i);
    gpr8[3*16 +: 16] = 16'h1234;
    gpr8[0 +: 16]    = 16'hBEEF;
    for (int i = 0; i < 16; i++) gpr16[i*16 +: 16] = 16'h2000 + 16'(i);
    gpr16[15*16 +: 16] = 16'hF00F;
    rb_d = 16'hA0B0; rbp_d = 16'hA1B1; pc_d = 16'h0100; ir_d = 16'h1E1E; fsr_d = 16'hF5F5;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_data", lbus_data, 0);
    chk("rst_valid", lbus_valid, 0);
    chk("rst_reqs", {io_req, mm_req}, 0);
    chk("rst_errs", {sel_err, timeout_err}, 0);
    n_rst = 1;
    step();

    // fast sources, table driven
    vecs = '{
      '{1'b1, 4'd3,  1'b1, 16'h1234, 1'b0},
      '{1'b1, 4'd7,  1'b1, 16'h1007, 1'b0},
      '{1'b1, 4'd8,  1'b1, 16'hA0B0, 1'b0},
      '{1'b1, 4'd9,  1'b1, 16'hA1B1, 1'b0},
      '{1'b1, 4'd13, 1'b1, 16'h1E1E, 1'b0},
      '{1'b1, 4'd14, 1'b1, 16'hF5F5, 1'b0},
      '{1'b1, 4'd15, 1'b1, 16'h0000, 1'b0},
      '{1'b0, 4'd5,  1'b0, 16'h0000, 1'b0},
      '{1'b1, 4'd10, 1'b1, 16'h0100, 1'b0},
      '{1'b1, 4'd0,  1'b1, 16'hBEEF, 1'b0},
      '{1'b0, 4'd2,  1'b0, 16'hBEEF, 1'b0}
    };
    foreach (vecs[i]) exp_q.push_back(vecs[i].exp_data);
    foreach (vecs[i]) begin
      logic [15:0] ed;
      issue = vecs[i].issue;
      sel   = vecs[i].sel;
      step();
      ed = exp_q.pop_front();
      chk($sformatf("vec%0d_valid", i), lbus_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_data", i), lbus_data, ed);
      chk($sformatf("vec%0d_sel_err", i), sel_err, vecs[i].exp_sel_err);
      chk($sformatf("vec%0d_ready", i), ready, 1);
    end
    issue = 0;

    // stray ack while idle is ignored
    mm_ack = 1; mm_rdata = 16'hDEAD;
    step();
    chk("stray_ack_valid", lbus_valid, 0);
    chk("stray_ack_data", lbus_data, 16'hBEEF);
    mm_ack = 0;

    // MM read acknowledged after 3 request cycles
    issue = 1; sel = 4'd12;
    step();
    issue = 0;
    chk("mm_req_rise", mm_req, 1);
    chk("mm_ready_low", ready, 0);
    chk("mm_no_valid", lbus_valid, 0);
    chk("mm_data_held", lbus_data, 16'hBEEF);
    step();
    chk("mm_req_c2", {mm_req, ready}, 2'b10);
    step();
    chk("mm_req_c3", {mm_req, ready}, 2'b10);
    mm_ack = 1; mm_rdata = 16'hCAFE;
    step();
    mm_ack = 0;
    chk("mm_valid", lbus_valid, 1);
    chk("mm_data", lbus_data, 16'hCAFE);
    chk("mm_req_drop", mm_req, 0);
    chk("mm_ready_back", ready, 1);
    chk("mm_no_timeout", timeout_err, 0);

    // IO read that times out; a second issue mid-wait is dropped
    issue = 1; sel = 4'd11;
    step();
    issue = 0;
    cyc = 0; both_req = 0; spurious = 0;
    if (io_req) cyc = 1;
    for (int i = 0; i < 40 && io_req; i++) begin
      issue = (i == 4); sel = 4'd3;
      step();
      if (io_req && mm_req) both_req = 1;
      if (io_req && lbus_valid) spurious = 1;
      if (io_req) cyc++;
    end
    issue = 0;
    chk("io_req_cycles", cyc, 15);
    chk("io_req_exclusive", both_req, 0);
    chk("io_wait_no_valid", spurious, 0);
    chk("io_to_valid", lbus_valid, 1);
    chk("io_to_data", lbus_data, 16'h0000);
    chk("io_to_err", timeout_err, 1);
    chk("io_to_ready", ready, 1);
    step();
    chk("io_to_err_sticky", timeout_err, 1);
    chk("io_after_valid", lbus_valid, 0);
    err_clr = 1;
    step();
    err_clr = 0;
    chk("err_clr", timeout_err, 0);

    // ack arriving on the timeout edge wins
    issue = 1; sel = 4'd11;
    step();
    issue = 0;
    repeat (14) step();
    chk("io_last_cycle_req", io_req, 1);
    io_ack = 1; io_rdata = 16'h5A5A;
    step();
    io_ack = 0;
    chk("ack_vs_to_valid", lbus_valid, 1);
    chk("ack_vs_to_data", lbus_data, 16'h5A5A);
    chk("ack_vs_to_err", timeout_err, 0);

    // reset during WAIT_MM
    issue = 1; sel = 4'd12;
    step();
    issue = 0;
    step();
    chk("pre_rst_mm_req", mm_req, 1);
    n_rst = 0;
    #1;
    chk("rst_mid_mm_req", mm_req, 0);
    chk("rst_mid_ready", ready, 1);
    chk("rst_mid_data", lbus_data, 0);
    @(posedge clk);
    #3;
    n_rst = 1;
    mm_ack = 1; mm_rdata = 16'h9999;
    step();
    mm_ack = 0;
    chk("late_ack_valid", lbus_valid, 0);
    chk("late_ack_data", lbus_data, 0);
    chk("late_ack_ready", {ready, mm_req}, 2'b10);

    // 16-GPR instance: R15, MM code, NLB code, first illegal code
    issue16 = 1; sel16 = 5'd15;
    step();
    chk("g16_r15", {valid16, data16}, {1'b1, 16'hF00F});
    sel16 = 5'b10100;
    step();
    issue16 = 0;
    chk("g16_mm_req", {mm_req16, ready16, valid16}, 3'b100);
    mm_ack16 = 1;
    step();
    mm_ack16 = 0;
    chk("g16_mm_data", {valid16, data16}, {1'b1, 16'h7777});
    issue16 = 1; sel16 = 5'b10111;
    step();
    chk("g16_nlb", {valid16, data16, sel_err16}, {1'b1, 16'h0000, 1'b0});
    sel16 = 5'd24;
    step();
    issue16 = 0;
    chk("g16_illegal", {valid16, data16, sel_err16}, {1'b1, 16'h0000, 1'b1});
    step();
    chk("g16_sel_err_pulse", {valid16, sel_err16}, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
